// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: state encoding and elaboration helpers shared by the serial adder/subtractor
package serial_add_sub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/busy/done request bus between sequencer and serial adder/subtractor
interface serial_add_sub_if #(parameter int WIDTH = 8);
  logic start, sub, cin, busy, done, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_sub_add_slice.sv
// add_slice: SLICE-bit ripple chain of fulladder cells, exposing the carry into its top bit
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic A,
  output logic cout
);
  assign A = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module add_slice #(parameter int SLICE = 1) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [SLICE:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    fulladder u_fa (.x(x[i]), .y(y[i]), .cin(c[i]), .A(s[i]), .cout(c[i+1]));
  end
  assign co = c[SLICE];
  assign cm = c[SLICE-1];
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle WIDTH-bit add/subtract, SLICE bits per clock with a registered carry
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input logic clk,
  input logic rst,
  serial_add_sub_if.slave bus
);
  localparam int STEPS = WIDTH / SLICE;
  localparam int CW = clog2(STEPS + 1);
  state_t state, nxt;
  logic [WIDTH-1:0] opa, opb, res, sum_q;
  logic [WIDTH+SLICE-1:0] cat;
  logic [CW-1:0] cnt;
  logic [SLICE-1:0] s;
  logic carry, cmsb, done_q, cout_q, ovf_q, co, cm, accept, last;
  assign accept = bus.start && state != ST_RUN;
  assign last = cnt == CW'(STEPS - 1);
  assign cat = {s, res};
  add_slice #(.SLICE(SLICE)) u_slice (
    .x(opa[SLICE-1:0]), .y(opb[SLICE-1:0]), .ci(carry), .s(s), .co(co), .cm(cm)
  );
  always_comb nxt = state == ST_RUN ? (last ? ST_FIN : ST_RUN) : (accept ? ST_RUN : ST_IDLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  // subtract is a + ~b + 1, so the inversion and the forced carry happen at accept time
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opa <= '0;
      opb <= '0;
      res <= '0;
      cnt <= '0;
      carry <= 1'b0;
      cmsb <= 1'b0;
      done_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        opa <= bus.a;
        opb <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub | bus.cin;
        cnt <= '0;
      end else if (state == ST_RUN) begin
        opa <= opa >> SLICE;
        opb <= opb >> SLICE;
        res <= cat[WIDTH+SLICE-1:SLICE];
        carry <= co;
        cnt <= cnt + CW'(1);
        if (last) cmsb <= cm;
      end
      done_q <= state == ST_FIN;
      if (state == ST_FIN) begin
        sum_q <= res;
        cout_q <= carry;
        ovf_q <= cmsb ^ carry;
      end
    end
  assign bus.busy = state == ST_RUN;
  assign bus.done = done_q;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed table plus corner sequences on an 8/1 instance, reference sweep on a 16/4 instance
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_add_sub_if #(.WIDTH(8)) i8 ();
  serial_add_sub_if #(.WIDTH(16)) i16 ();
  serial_add_sub #(.WIDTH(8), .SLICE(1)) dut8 (.clk(clk), .rst(rst), .bus(i8));
  serial_add_sub #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst(rst), .bus(i16));
  typedef struct {
    logic sub;
    logic [7:0] a, b;
    logic cin;
    logic [7:0] sum;
    logic cout, ovf;
  } vec_t;
  vec_t tbl[10];
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic go8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    i8.start = 1'b1; i8.sub = s; i8.a = x; i8.b = y; i8.cin = c;
    @(posedge clk); #1;
    i8.start = 1'b0; i8.sub = ~s; i8.a = ~x; i8.b = ~y; i8.cin = ~c;
  endtask
  task automatic wait8(output int lat, output int bc);
    lat = 0; bc = 0;
    while (i8.done !== 1'b1 && lat < 40) begin
      if (i8.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic go16(input logic s, input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    i16.start = 1'b1; i16.sub = s; i16.a = x; i16.b = y; i16.cin = c;
    @(posedge clk); #1;
    i16.start = 1'b0; i16.a = ~x; i16.b = ~y;
  endtask
  task automatic wait16(output int lat);
    lat = 0;
    while (i16.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  initial begin
    int lat, bc, lat2, dn;
    logic [16:0] r;
    logic [15:0] x, y, es;
    logic s, c, ec, eo;
    tbl[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h07, 8'h07, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    i8.start = 1'b0; i8.sub = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
    i16.start = 1'b0; i16.sub = 1'b0; i16.a = '0; i16.b = '0; i16.cin = 1'b0;
    #12;
    check("reset8", {i8.busy, i8.done, i8.cout, i8.ovf, i8.sum}, 0);
    check("reset16", {i16.busy, i16.done, i16.cout, i16.ovf, i16.sum}, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      go8(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin);
      wait8(lat, bc);
      check($sformatf("v%0d latency", i), lat, 9);
      check($sformatf("v%0d busy_cycles", i), bc, 8);
      check($sformatf("v%0d sum", i), i8.sum, tbl[i].sum);
      check($sformatf("v%0d cout", i), i8.cout, tbl[i].cout);
      check($sformatf("v%0d ovf", i), i8.ovf, tbl[i].ovf);
      @(posedge clk); #1;
      check($sformatf("v%0d done_pulse", i), i8.done, 0);
      check($sformatf("v%0d sum_hold", i), i8.sum, tbl[i].sum);
    end
    // start during RUN must not restart or resample
    go8(1'b0, 8'h0F, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    i8.start = 1'b1; i8.sub = 1'b1; i8.a = 8'h55; i8.b = 8'h22;
    @(posedge clk); #1;
    i8.start = 1'b0;
    check("ignored_sum_hold", i8.sum, 8'hFF);
    wait8(lat, bc);
    check("ignored latency", lat + 4, 9);
    check("ignored sum", i8.sum, 8'h10);
    // start held during FIN starts the next op with no idle gap
    go8(1'b0, 8'h0F, 8'h01, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("fin busy", i8.busy, 0);
    check("fin done", i8.done, 0);
    i8.start = 1'b1; i8.sub = 1'b1; i8.a = 8'h20; i8.b = 8'h03; i8.cin = 1'b0;
    @(posedge clk); #1;
    i8.start = 1'b0;
    check("b2b first done", i8.done, 1);
    check("b2b first sum", i8.sum, 8'h10);
    check("b2b second busy", i8.busy, 1);
    @(posedge clk); #1;
    wait8(lat2, bc);
    check("b2b second latency", lat2 + 1, 9);
    check("b2b second result", {i8.cout, i8.ovf, i8.sum}, {2'b10, 8'h1D});
    // asynchronous reset in the middle of an operation
    go8(1'b0, 8'hFF, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrst outputs", {i8.busy, i8.done, i8.cout, i8.ovf, i8.sum}, 0);
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (i8.done) dn++;
    end
    check("midrst no_done", dn, 0);
    go8(1'b0, 8'h7F, 8'h01, 1'b0);
    wait8(lat, bc);
    check("post_rst latency", lat, 9);
    check("post_rst result", {i8.cout, i8.ovf, i8.sum}, {2'b01, 8'h80});
    go16(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    wait16(lat);
    check("w16 latency", lat, 5);
    check("w16 result", {i16.cout, i16.ovf, i16.sum}, {2'b00, 16'h2201});
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = (i % 10 == 0) ? x : 16'($urandom);
      if (s) begin
        es = x - y;
        ec = x >= y;
        eo = (x[15] != y[15]) && (es[15] != x[15]);
      end else begin
        r = {1'b0, x} + {1'b0, y} + {16'd0, c};
        es = r[15:0];
        ec = r[16];
        eo = (x[15] == y[15]) && (es[15] != x[15]);
      end
      go16(s, x, y, c);
      wait16(lat);
      check($sformatf("rnd%0d latency", i), lat, 5);
      check($sformatf("rnd%0d s=%0d a=%h b=%h c=%0d", i, s, x, y, c), {i16.cout, i16.ovf, i16.sum}, {ec, eo, es});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor: WIDTH-bit operands processed SLICE bits per clock through a SLICE-bit ripple slice, carry held in a register between steps.
- Successor to the single-bit combinational full-adder cell. Adds operand width, a selectable per-cycle slice width, subtract mode, signed overflow and a start/busy/done handshake.
- Sits between the lab sequencer (issues start) and the result logic (samples on done).

Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH >= 2.
- SLICE, 1, bits processed per clock; must divide WIDTH exactly; SLICE = WIDTH gives a single-step adder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on a rising clk edge
- sub  input  1  0 = add, 1 = subtract; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in for add; ignored when sub=1
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/cout/ovf are updated
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out; in subtract mode 0 = borrow
- ovf  output  1  registered two's-complement overflow

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE.
  - busy, done, sum, cout and ovf all = 0.
  - Internal operand/result shift registers, carry and step counter cleared.
  - The in-flight operation is discarded with no done pulse.
- Constants:
  - STEPS = WIDTH/SLICE.
  - The step counter is clog2(STEPS+1) bits wide.
- States: IDLE, RUN, FIN.
- IDLE:
  - If start=1, on that edge latch opA = a.
  - Latch opB = sub ? ~b : b.
  - Set carry = sub ? 1 : cin.
  - Set step counter = 0 and go to RUN.
  - busy = 1 from the next cycle.
- RUN, each cycle:
  - The slice adds opA[SLICE-1:0] + opB[SLICE-1:0] + carry.
  - The SLICE result bits shift into the top of the result register.
  - opA and opB shift right by SLICE.
  - carry = slice carry-out.
  - The step counter increments.
  - On the final step (counter = STEPS-1), capture the carry into the MSB (carry out of bit WIDTH-2), then go to FIN.
- FIN, one cycle:
  - sum = assembled result; cout = final carry.
  - ovf = carry into MSB XOR final carry.
  - done = 1 and busy = 0.
  - Next state is IDLE, or RUN if start=1 in this cycle; back-to-back operations are accepted.
- Latency and output hold:
  - done asserts exactly STEPS+1 rising edges after the edge that accepted start.
  - sum, cout and ovf hold their values until the next done; they never change mid-operation.
- Handshake rules:
  - start while busy=1 (RUN) is ignored. Operands are not re-sampled and the operation is not restarted.
  - a, b, sub and cin may change freely after the accept edge.
- Arithmetic:
  - Add mode: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1).
  - Subtract mode: sum = a - b (mod 2^WIDTH); cout = 1 when a >= b unsigned.
  - ovf is the signed overflow of the same operation.
- Wrap-around: at 0xFF + 0x01 the result wraps to 0 with cout = 1; no saturation.
- SLICE = WIDTH: one RUN cycle; done two edges after start.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2;
  - a localparam function for clog2.
- One sub-module, add_slice (SLICE parameter): a ripple chain of the existing fulladder cell (x, y, cin -> A, cout).
  - Outputs the SLICE sum bits, the carry-out, and the carry into its top bit (for ovf).
- Top level holds the FSM, the counter and the shift/result registers.

Test Plan:
- WIDTH=8, SLICE=1, add a=0x0F, b=0x01, cin=0 -> done 9 edges after accept; sum=0x10, cout=0, ovf=0; busy high for 8 cycles.
- Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Add a=0x00, b=0x00, cin=1 -> sum=0x01.
- Subtract a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0. Subtract a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Pulse start again at step 3 with different operands -> ignored; first result delivered on schedule. Start held high during the FIN cycle -> second operation accepted with no idle gap.
- Assert rst at step 4 of an operation -> outputs 0 immediately (asynchronously), no done pulse; a new start after reset completes normally.
- WIDTH=16, SLICE=4: a=0x1234, b=0x0FCD, add -> done 5 edges after accept, sum=0x2201, cout=0; a random sweep of 200 vectors is checked against a behavioural reference model.
